// File: rtl/rv32i_mc_controller.sv
// Multi-cycle sequencing controller for the RV32I core: steps each instruction
// through fetch/decode/execute/memory/writeback, counts retirements, traps on errors.
module rv32i_mc_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int INSTRET_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  output logic                 imem_req,
  output logic                 ir_we,
  output logic                 alu_en,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic                 rf_we,
  output logic                 pc_we,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [INSTRET_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_t;

  localparam logic [6:0] OP_ALU_R = 7'b0110011;
  localparam logic [6:0] OP_ALU_I = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_IMEM_TO = 2'b10;
  localparam logic [1:0] CAUSE_DMEM_TO = 2'b11;

  localparam int             TW        = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit             TO_EN     = (MEM_TIMEOUT > 0);
  localparam logic [TW-1:0]  WAIT_LAST = TW'(MEM_TIMEOUT - 1);

  state_t                 state_r;
  logic                   is_mem_r;
  logic                   is_store_r;
  logic [TW-1:0]          wait_r;
  logic [1:0]             cause_r;
  logic [INSTRET_W-1:0]   instret_r;
  logic                   timeout_s;
  logic                   retire_s;

  // Timeout fires on the last allowed wait cycle; retirement is WB or a completed store.
  always_comb begin
    timeout_s = TO_EN && (wait_r == WAIT_LAST);
    retire_s  = (state_r == S_WRITEBACK) ||
                ((state_r == S_MEM) && is_store_r && dmem_ready);
  end

  // Sequencing state, registered opcode class, wait counter and retirement count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_FETCH;
      is_mem_r   <= 1'b0;
      is_store_r <= 1'b0;
      wait_r     <= '0;
      cause_r    <= 2'b00;
      instret_r  <= '0;
    end else begin
      if (retire_s) begin
        instret_r <= instret_r + {{(INSTRET_W-1){1'b0}}, 1'b1};
      end
      case (state_r)
        S_FETCH: begin
          if (imem_ready) begin
            state_r <= S_DECODE;
          end else if (timeout_s) begin
            state_r <= S_TRAP;
            cause_r <= CAUSE_IMEM_TO;
          end else begin
            wait_r <= wait_r + {{(TW-1){1'b0}}, 1'b1};
          end
        end
        S_DECODE: begin
          case (opcode)
            OP_ALU_R, OP_ALU_I: begin
              is_mem_r   <= 1'b0;
              is_store_r <= 1'b0;
              state_r    <= S_EXECUTE;
            end
            OP_LOAD: begin
              is_mem_r   <= 1'b1;
              is_store_r <= 1'b0;
              state_r    <= S_EXECUTE;
            end
            OP_STORE: begin
              is_mem_r   <= 1'b1;
              is_store_r <= 1'b1;
              state_r    <= S_EXECUTE;
            end
            default: begin
              state_r <= S_TRAP;
              cause_r <= CAUSE_ILLEGAL;
            end
          endcase
        end
        S_EXECUTE: begin
          wait_r  <= '0;
          state_r <= is_mem_r ? S_MEM : S_WRITEBACK;
        end
        S_MEM: begin
          if (dmem_ready) begin
            wait_r  <= '0;
            state_r <= is_store_r ? S_FETCH : S_WRITEBACK;
          end else if (timeout_s) begin
            state_r <= S_TRAP;
            cause_r <= CAUSE_DMEM_TO;
          end else begin
            wait_r <= wait_r + {{(TW-1){1'b0}}, 1'b1};
          end
        end
        S_WRITEBACK: begin
          wait_r  <= '0;
          state_r <= S_FETCH;
        end
        S_TRAP: begin
          state_r <= S_TRAP;
        end
        default: begin
          state_r <= S_TRAP;
          cause_r <= CAUSE_ILLEGAL;
        end
      endcase
    end
  end

  // Moore decode of the state; ready-qualified strobes; everything forced low during reset.
  always_comb begin
    imem_req   = 1'b0;
    ir_we      = 1'b0;
    alu_en     = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    rf_we      = 1'b0;
    pc_we      = 1'b0;
    trap       = 1'b0;
    trap_cause = 2'b00;
    instret    = '0;
    if (!rst) begin
      instret = instret_r;
      pc_we   = retire_s;
      case (state_r)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ready;
        end
        S_EXECUTE:   alu_en = 1'b1;
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = is_store_r;
        end
        S_WRITEBACK: rf_we = 1'b1;
        S_TRAP: begin
          trap       = 1'b1;
          trap_cause = cause_r;
        end
        default: trap = 1'b0;
      endcase
    end else begin
      instret = '0;
    end
  end

endmodule

// File: tb/tb_rv32i_mc_controller.sv
// Directed bench for rv32i_mc_controller (MEM_TIMEOUT=4, INSTRET_W=4) with
// hand-computed per-cycle output vectors.
module tb_rv32i_mc_controller;

  logic       clk;
  logic       rst;
  logic [6:0] opcode;
  logic       imem_ready;
  logic       dmem_ready;
  logic       imem_req, ir_we, alu_en, dmem_req, dmem_we, rf_we, pc_we, trap;
  logic [1:0] trap_cause;
  logic [3:0] instret;
  logic [9:0] ov;

  int checks;
  int failures;

  localparam logic [6:0] OP_A = 7'b0010011;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_J = 7'b1101111;

  // {imem_req, ir_we, alu_en, dmem_req, dmem_we, rf_we, pc_we, trap, trap_cause}
  localparam logic [9:0] V_0   = 10'b0000000000;
  localparam logic [9:0] V_F   = 10'b1100000000;
  localparam logic [9:0] V_FW  = 10'b1000000000;
  localparam logic [9:0] V_E   = 10'b0010000000;
  localparam logic [9:0] V_WB  = 10'b0000011000;
  localparam logic [9:0] V_ML  = 10'b0001000000;
  localparam logic [9:0] V_MS  = 10'b0001100000;
  localparam logic [9:0] V_MSR = 10'b0001101000;
  localparam logic [9:0] V_TI  = 10'b0000000101;
  localparam logic [9:0] V_TF  = 10'b0000000110;
  localparam logic [9:0] V_TM  = 10'b0000000111;

  rv32i_mc_controller #(.MEM_TIMEOUT(4), .INSTRET_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_we(ir_we), .alu_en(alu_en),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .rf_we(rf_we), .pc_we(pc_we),
    .trap(trap), .trap_cause(trap_cause), .instret(instret)
  );

  assign ov = {imem_req, ir_we, alu_en, dmem_req, dmem_we, rf_we, pc_we, trap, trap_cause};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's inputs after the falling edge, then check the outputs.
  task automatic cyc(input string tag, input logic r, input logic ir, input logic dr,
                     input logic [6:0] op, input logic [9:0] exp);
    @(negedge clk);
    rst = r; imem_ready = ir; dmem_ready = dr; opcode = op;
    #1;
    checks++;
    assert (ov === exp) else begin
      failures++;
      $error("FAIL %s outputs=%b expected=%b", tag, ov, exp);
    end
  endtask

  task automatic cnt(input string tag, input logic [3:0] exp);
    checks++;
    assert (instret === exp) else begin
      failures++;
      $error("FAIL %s instret=%0d expected=%0d", tag, instret, exp);
    end
  endtask

  task automatic alu_instr(input string tag);
    cyc(tag, 1'b0, 1'b1, 1'b0, OP_A, V_F);
    cyc(tag, 1'b0, 1'b0, 1'b0, OP_A, V_0);
    cyc(tag, 1'b0, 1'b0, 1'b0, OP_A, V_E);
    cyc(tag, 1'b0, 1'b0, 1'b0, OP_A, V_WB);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0; opcode = OP_A;

    cyc("rst_a", 1'b1, 1'b0, 1'b0, OP_A, V_0);
    cyc("rst_b", 1'b1, 1'b1, 1'b1, OP_A, V_0);
    cnt("rst_instret", 4'd0);

    // Three back-to-back ADDI, always-ready memories.
    for (int i = 0; i < 3; i++) alu_instr("addi");

    // Load with dmem_ready two cycles late.
    cyc("ld_f",  1'b0, 1'b1, 1'b0, OP_L, V_F);
    cnt("addi_instret", 4'd3);
    cyc("ld_d",  1'b0, 1'b0, 1'b0, OP_L, V_0);
    cyc("ld_e",  1'b0, 1'b0, 1'b0, OP_L, V_E);
    cyc("ld_m0", 1'b0, 1'b0, 1'b0, OP_L, V_ML);
    cyc("ld_m1", 1'b0, 1'b0, 1'b0, OP_L, V_ML);
    cyc("ld_m2", 1'b0, 1'b0, 1'b1, OP_L, V_ML);
    cyc("ld_wb", 1'b0, 1'b0, 1'b0, OP_L, V_WB);

    // Store with dmem_ready two cycles late; stray readies in D/E are ignored.
    cyc("st_f",  1'b0, 1'b1, 1'b0, OP_S, V_F);
    cnt("ld_instret", 4'd4);
    cyc("st_d",  1'b0, 1'b1, 1'b1, OP_S, V_0);
    cyc("st_e",  1'b0, 1'b1, 1'b1, OP_S, V_E);
    cyc("st_m0", 1'b0, 1'b0, 1'b0, OP_S, V_MS);
    cyc("st_m1", 1'b0, 1'b0, 1'b0, OP_S, V_MS);
    cyc("st_m2", 1'b0, 1'b0, 1'b1, OP_S, V_MSR);

    // JAL is illegal here: trap after decode, held until reset.
    cyc("jal_f", 1'b0, 1'b1, 1'b0, OP_J, V_F);
    cnt("st_instret", 4'd5);
    cyc("jal_d", 1'b0, 1'b0, 1'b0, OP_J, V_0);
    for (int i = 0; i < 20; i++) cyc("jal_trap", 1'b0, 1'b1, 1'b1, OP_A, V_TI);
    cnt("jal_instret", 4'd5);
    cyc("rst_trap", 1'b1, 1'b0, 1'b0, OP_A, V_0);
    cnt("rst_trap_instret", 4'd0);

    // Fetch timeout after four request cycles.
    for (int i = 0; i < 4; i++) cyc("if_wait", 1'b0, 1'b0, 1'b0, OP_A, V_FW);
    cyc("if_trap",  1'b0, 1'b1, 1'b1, OP_A, V_TF);
    cyc("if_trap2", 1'b0, 1'b1, 1'b0, OP_A, V_TF);
    cyc("rst_if", 1'b1, 1'b0, 1'b0, OP_A, V_0);

    // Ready on the last allowed cycle wins.
    for (int i = 0; i < 3; i++) cyc("if_late_w", 1'b0, 1'b0, 1'b0, OP_A, V_FW);
    cyc("if_late_f",  1'b0, 1'b1, 1'b0, OP_A, V_F);
    cyc("if_late_d",  1'b0, 1'b0, 1'b0, OP_A, V_0);
    cyc("if_late_e",  1'b0, 1'b0, 1'b0, OP_A, V_E);
    cyc("if_late_wb", 1'b0, 1'b0, 1'b0, OP_A, V_WB);

    // Data-memory timeout on a load.
    cyc("dto_f", 1'b0, 1'b1, 1'b0, OP_L, V_F);
    cnt("dto_instret0", 4'd1);
    cyc("dto_d", 1'b0, 1'b0, 1'b0, OP_L, V_0);
    cyc("dto_e", 1'b0, 1'b0, 1'b0, OP_L, V_E);
    for (int i = 0; i < 4; i++) cyc("dto_m", 1'b0, 1'b0, 1'b0, OP_L, V_ML);
    cyc("dto_trap", 1'b0, 1'b0, 1'b1, OP_L, V_TM);
    cnt("dto_instret1", 4'd1);
    cyc("rst_dto", 1'b1, 1'b0, 1'b0, OP_A, V_0);

    // Reset while a data request is pending.
    alu_instr("pre_alu");
    cyc("rm_f", 1'b0, 1'b1, 1'b0, OP_L, V_F);
    cnt("rm_instret", 4'd1);
    cyc("rm_d", 1'b0, 1'b0, 1'b0, OP_L, V_0);
    cyc("rm_e", 1'b0, 1'b0, 1'b0, OP_L, V_E);
    cyc("rm_m", 1'b0, 1'b0, 1'b0, OP_L, V_ML);
    cyc("rm_rst", 1'b1, 1'b0, 1'b1, OP_L, V_0);
    cnt("rm_rst_instret", 4'd0);
    cyc("rm_after", 1'b0, 1'b0, 1'b0, OP_A, V_FW);
    cnt("rm_after_instret", 4'd0);
    cyc("rst_wrap", 1'b1, 1'b0, 1'b0, OP_A, V_0);

    // 17 ALU instructions on a 4-bit counter: wraps 15 -> 0, ends at 1.
    for (int k = 0; k < 17; k++) begin
      cyc("wrap_f", 1'b0, 1'b1, 1'b0, OP_A, V_F);
      cnt("wrap_instret", 4'(k % 16));
      cyc("wrap_d", 1'b0, 1'b0, 1'b0, OP_A, V_0);
      cyc("wrap_e", 1'b0, 1'b0, 1'b0, OP_A, V_E);
      cyc("wrap_wb", 1'b0, 1'b0, 1'b0, OP_A, V_WB);
    end
    cyc("wrap_end", 1'b0, 1'b0, 1'b0, OP_A, V_FW);
    cnt("wrap_final", 4'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv32i_mc_controller.md
# rv32i_mc_controller

Multi-cycle sequencing controller for the RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback phases, and drives the enables for the PC, the instruction register, the ALU, the data memory and the register-file write port. It sits between the instruction/data memory handshakes and the datapath, and its `opcode` input comes from the instruction-register output. It counts retired instructions and traps on illegal opcodes or memory timeouts.

## Interface
- `MEM_TIMEOUT`, default 16: maximum number of wait cycles on a memory request before a timeout trap; 0 disables the timeout.
- `INSTRET_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  clock; one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `opcode`  in  7  instruction bits [6:0], taken from the instruction-register output.
- `imem_ready`  in  1  instruction memory has accepted the request and `rdata` is valid this cycle.
- `dmem_ready`  in  1  data-memory access completes this cycle.
- `imem_req`  out  1  instruction fetch request.
- `ir_we`  out  1  instruction-register load strobe.
- `alu_en`  out  1  ALU / address-calculation enable.
- `dmem_req`  out  1  data-memory request.
- `dmem_we`  out  1  data-memory write (valid only with `dmem_req`).
- `rf_we`  out  1  register-file write strobe.
- `pc_we`  out  1  PC advance strobe; marks retirement.
- `trap`  out  1  controller halted on an error.
- `trap_cause`  out  2  01 illegal opcode, 10 imem timeout, 11 dmem timeout, 00 none.
- `instret`  out  INSTRET_W  retired-instruction count.

## Operation
- States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP. All outputs are Moore-decoded from the state, except the strobes qualified by `*_ready`.
- FETCH: `imem_req`=1 is held until `imem_ready`. On `imem_ready`, `ir_we`=1 in the same cycle, then go to DECODE.
- DECODE: opcode class is decided.
  - ALU class is 0110011 or 0010011; memory class is 0000011 (load) or 0100011 (store). Either class goes to EXECUTE.
  - Any other opcode goes to TRAP with cause 01.
- EXECUTE: `alu_en`=1 for one cycle. ALU class goes to WRITEBACK; memory class goes to MEM.
- MEM: `dmem_req`=1; `dmem_we`=1 for a store only. Hold until `dmem_ready`.
  - Store with `dmem_ready`: `pc_we`=1 in that cycle (retire), then go to FETCH.
  - Load with `dmem_ready`: go to WRITEBACK.
- WRITEBACK: `rf_we`=1 and `pc_we`=1 for one cycle (retire), then go to FETCH.
- TRAP: `trap`=1, `trap_cause` held, all strobes and requests are 0. The only exit is `rst`.
- `instret` increments by 1 on every cycle with `pc_we`=1 and wraps modulo 2^INSTRET_W without flagging.
- Timeout: a wait counter clears on entry to FETCH or MEM and increments on each cycle in that state with ready low.
  - If ready is still low on the cycle where the counter equals MEM_TIMEOUT-1, go to TRAP with cause 10 (FETCH) or 11 (MEM).
  - Ready asserted in that same cycle wins: no trap.
- The class decision is registered in DECODE. `opcode` is ignored in every other state.

## Timing
- Reset: while `rst`=1, every output is 0 (including `imem_req`, `trap`, `trap_cause`, `instret`), and the state loads FETCH. The first cycle after `rst` falls has `imem_req`=1.
- Reset mid-operation (any state, including MEM with a request pending, or TRAP): the controller aborts in the next cycle with no retirement, and `instret` clears.
- Latency with zero-wait memory (ready in the first request cycle):
  - ALU: 4 cycles (F, D, E, WB).
  - Load: 5 cycles (F, D, E, M, WB).
  - Store: 4 cycles (F, D, E, M).
- Each memory wait cycle adds exactly 1 cycle.
- Strobe widths:
  - `ir_we`, `pc_we`, `rf_we` and `alu_en` are single-cycle pulses per instruction.
  - `imem_req` and `dmem_req` stay high continuously until their ready arrives.
  - A request never deasserts before its ready, except on trap or reset.
- Ready inputs arriving outside their request state are ignored.
- Throughput is one instruction at a time; there is no overlap.

## Test plan
- ADDI (0010011) with always-ready memories, 3 back-to-back:
  - `ir_we` in cycles 1/5/9, `rf_we` and `pc_we` in cycles 4/8/12.
  - `instret`=3 after cycle 12.
- Load then store, with `dmem_ready` delayed 2 cycles:
  - Load retires 7 cycles after its fetch starts; store retires 6 cycles after its fetch starts.
  - `dmem_we` is high only during the store MEM cycles; `rf_we` never fires for the store.
- Opcode 1101111 (JAL):
  - TRAP entered the cycle after DECODE; `trap`=1, `trap_cause`=01.
  - No `pc_we`; `instret` unchanged; controller stays in TRAP for 20 cycles until `rst`.
- MEM_TIMEOUT=4, `imem_ready` held low:
  - `imem_req` is high for 4 cycles, then `trap_cause`=10.
  - Repeat with `imem_ready` rising in the 4th cycle: no trap, normal fetch.
- `rst` asserted for one cycle while `dmem_req` is pending:
  - All outputs 0 in the `rst` cycle, `instret`=0, `imem_req`=1 the following cycle.
- INSTRET_W=4, 17 ALU instructions: `instret` wraps 15→0 and reads 1 at the end.
